usb_fs_tx: RTL and testbench

Full-speed USB transmit serializer in the clk_usb domain. It is the counterpart stage on the same dp/dn pair as the receive path. It takes a PID and an optional stream of payload bytes from the protocol engine, then drives SYNC, PID, data, CRC16 and EOP. The line coding is NRZI with bit stuffing, one bit every USB_CLOCK_MULT clocks. It supports handshake packets and data packets; the device never sends tokens.

---
 rtl/usb_fs_pkg.sv | 39 +++
 rtl/usb_fs_tx_crc16.sv | 27 ++
 rtl/usb_fs_tx.sv | 186 ++++++++++++++++++
 tb/tb_usb_fs_tx.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_fs_pkg.sv
// usb_fs_pkg: shared constants and types for the full-speed USB datapath.
package usb_fs_pkg;

  localparam int USB_CLOCK_MULT_DEFAULT = 4;

  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;

  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // Sent LSB first: seven zeros then a one (KJKJKJKK on the wire).
  localparam logic [7:0] SYNC_BITS = 8'h80;

  // Encoded as {dp, dn}.
  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_K   = 2'b01,
    LS_J   = 2'b10
  } line_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_CRC,
    ST_EOP
  } tx_state_t;

  function automatic line_t nrzi(input line_t cur, input logic b);
    if (b) return cur;
    return (cur == LS_J) ? LS_K : LS_J;
  endfunction

endpackage

// File: rtl/usb_fs_tx_crc16.sv
// usb_fs_tx_crc16: serial USB CRC16, fed LSB-first data bits,
// remainder exposed inverted for MSB-first shift-out.
module usb_fs_tx_crc16
  import usb_fs_pkg::*;
(
  input  logic        clk_usb,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc_inv
);

  logic [15:0] crc;

  always_ff @(posedge clk_usb) begin
    if (reset || clr) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= {crc[14:0], 1'b0} ^
             ((crc[15] ^ bit_in) ? CRC16_POLY : 16'h0000);
    end
  end

  assign crc_inv = ~crc;

endmodule

// File: rtl/usb_fs_tx.sv
// usb_fs_tx: full-speed USB transmit serializer (SYNC, PID, data,
// CRC16, EOP) with NRZI line coding and bit stuffing.
module usb_fs_tx
  import usb_fs_pkg::*;
#(
  parameter int USB_CLOCK_MULT = USB_CLOCK_MULT_DEFAULT
) (
  input  logic       clk_usb,
  input  logic       reset,
  input  logic       pkt_start,
  input  logic [3:0] pid,
  input  logic       tx_data_avail,
  input  logic [7:0] tx_data,
  output logic       tx_data_get,
  output logic       busy,
  output logic       pkt_end,
  output logic       oe,
  output logic       dp,
  output logic       dn
);

  localparam int TW =
    (USB_CLOCK_MULT > 1) ? $clog2(USB_CLOCK_MULT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(USB_CLOCK_MULT - 1);

  tx_state_t     state, state_n;
  line_t         line, line_n;
  logic [TW-1:0] timer;
  logic [3:0]    idx, idx_n;
  logic [6:0]    sh, sh_n;
  logic [2:0]    ones, ones_n;
  logic [3:0]    pid_q, pid_n;
  logic          oe_n, end_n;
  logic          tick, stuff_due;
  logic          send, bit_v;
  logic          crc_clr, crc_en;
  logic [15:0]   crc_inv;
  logic [3:0]    crc_idx;

  usb_fs_tx_crc16 u_crc (
    .clk_usb (clk_usb),
    .reset   (reset),
    .clr     (crc_clr),
    .en      (crc_en),
    .bit_in  (bit_v),
    .crc_inv (crc_inv)
  );

  assign tick = (state != ST_IDLE) && (timer == TMAX);
  assign stuff_due = (state inside {ST_PID, ST_DATA, ST_CRC}) &&
                     (ones == 3'd6);
  assign crc_idx = 4'd15 - (idx + 4'd1);

  always_ff @(posedge clk_usb) begin
    if (reset || state == ST_IDLE || tick) timer <= '0;
    else timer <= timer + 1'b1;
  end

  // sh holds the not-yet-sent bits of the current byte, next bit in sh[0].
  always_comb begin
    state_n     = state;
    line_n      = line;
    idx_n       = idx;
    sh_n        = sh;
    ones_n      = ones;
    pid_n       = pid_q;
    oe_n        = oe;
    end_n       = 1'b0;
    tx_data_get = 1'b0;
    crc_clr     = 1'b0;
    crc_en      = 1'b0;
    send        = 1'b0;
    bit_v       = 1'b0;
    if (state == ST_IDLE) begin
      if (pkt_start) begin
        state_n = ST_SYNC;
        idx_n   = '0;
        sh_n    = SYNC_BITS[7:1];
        ones_n  = '0;
        pid_n   = pid;
        oe_n    = 1'b1;
        crc_clr = 1'b1;
        line_n  = nrzi(LS_J, SYNC_BITS[0]);
      end
    end else if (tick) begin
      if (stuff_due) begin
        line_n = nrzi(line, 1'b0);
        ones_n = '0;
      end else begin
        unique case (state)
          ST_SYNC, ST_PID, ST_DATA: begin
            if (idx != 4'd7) begin
              idx_n  = idx + 4'd1;
              sh_n   = {1'b0, sh[6:1]};
              send   = 1'b1;
              bit_v  = sh[0];
              crc_en = (state == ST_DATA);
            end else if (state == ST_SYNC) begin
              state_n = ST_PID;
              idx_n   = '0;
              sh_n    = {~pid_q, pid_q[3:1]};
              send    = 1'b1;
              bit_v   = pid_q[0];
            end else if (state == ST_PID &&
                         pid_q[1:0] != PID_DATA0[1:0]) begin
              state_n = ST_EOP;
              idx_n   = '0;
              line_n  = LS_SE0;
              ones_n  = '0;
            end else if (tx_data_avail) begin
              state_n     = ST_DATA;
              idx_n       = '0;
              sh_n        = tx_data[7:1];
              tx_data_get = 1'b1;
              send        = 1'b1;
              bit_v       = tx_data[0];
              crc_en      = 1'b1;
            end else begin
              state_n = ST_CRC;
              idx_n   = '0;
              send    = 1'b1;
              bit_v   = crc_inv[15];
            end
          end
          ST_CRC: begin
            if (idx != 4'd15) begin
              idx_n = idx + 4'd1;
              send  = 1'b1;
              bit_v = crc_inv[crc_idx];
            end else begin
              state_n = ST_EOP;
              idx_n   = '0;
              line_n  = LS_SE0;
              ones_n  = '0;
            end
          end
          ST_EOP: begin
            if (idx == 4'd0) begin
              idx_n = 4'd1;
            end else if (idx == 4'd1) begin
              idx_n  = 4'd2;
              line_n = LS_J;
            end else begin
              state_n = ST_IDLE;
              idx_n   = '0;
              oe_n    = 1'b0;
              end_n   = 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (send) begin
        line_n = nrzi(line, bit_v);
        if (state_n != ST_SYNC) ones_n = bit_v ? ones + 3'd1 : 3'd0;
      end
    end
  end

  always_ff @(posedge clk_usb) begin
    if (reset) begin
      state   <= ST_IDLE;
      line    <= LS_J;
      idx     <= '0;
      sh      <= '0;
      ones    <= '0;
      pid_q   <= '0;
      oe      <= 1'b0;
      pkt_end <= 1'b0;
    end else begin
      state   <= state_n;
      line    <= line_n;
      idx     <= idx_n;
      sh      <= sh_n;
      ones    <= ones_n;
      pid_q   <= pid_n;
      oe      <= oe_n;
      pkt_end <= end_n;
    end
  end

  assign busy = (state != ST_IDLE);
  assign dp   = line[1];
  assign dn   = line[0];

endmodule

// File: tb/tb_usb_fs_tx.sv
// tb_usb_fs_tx: vector table, directed corner cases and random packets
// checked against a bit-level model of the USB wire encoding.
module tb_usb_fs_tx;

  localparam logic [1:0] LJ = 2'b10;
  localparam logic [1:0] LK = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;

  logic clk_usb = 1'b0;
  always #5 clk_usb = ~clk_usb;

  logic       reset = 1'b1;
  logic       pkt_start = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] pid = 4'h0;
  logic       tx_data_avail = 1'b0;
  logic [7:0] tx_data = 8'h00;

  logic start4, get4, busy4, end4, oe4, dp4, dn4;
  logic start5, get5, busy5, end5, oe5, dp5, dn5;
  logic get_m, busy_m, end_m, oe_m, dp_m, dn_m;

  assign start4 = pkt_start & ~sel;
  assign start5 = pkt_start & sel;
  assign get_m  = sel ? get5 : get4;
  assign busy_m = sel ? busy5 : busy4;
  assign end_m  = sel ? end5 : end4;
  assign oe_m   = sel ? oe5 : oe4;
  assign dp_m   = sel ? dp5 : dp4;
  assign dn_m   = sel ? dn5 : dn4;

  usb_fs_tx #(.USB_CLOCK_MULT(4)) u4 (
    .clk_usb(clk_usb), .reset(reset), .pkt_start(start4), .pid(pid),
    .tx_data_avail(tx_data_avail), .tx_data(tx_data),
    .tx_data_get(get4), .busy(busy4), .pkt_end(end4),
    .oe(oe4), .dp(dp4), .dn(dn4));

  usb_fs_tx #(.USB_CLOCK_MULT(5)) u5 (
    .clk_usb(clk_usb), .reset(reset), .pkt_start(start5), .pid(pid),
    .tx_data_avail(tx_data_avail), .tx_data(tx_data),
    .tx_data_get(get5), .busy(busy5), .pkt_end(end5),
    .oe(oe5), .dp(dp5), .dn(dn5));

  int n_pass = 0;
  int n_chk = 0;

  logic [7:0] src_q[$];
  logic [1:0] exp_q[$];
  logic [1:0] cap_q[$];
  logic [7:0] dec_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  task automatic drive_src();
    tx_data_avail = (src_q.size() > 0);
    tx_data = (src_q.size() > 0) ? src_q[0] : 8'h00;
  endtask

  // Wire model: bit list -> stuffing -> NRZI levels, one entry per bit.
  task automatic build_exp(input logic [3:0] p);
    bit body[$];
    bit all[$];
    logic [15:0] c;
    logic [7:0] pb;
    logic [1:0] lv;
    int run;
    exp_q.delete();
    pb = {~p, p};
    for (int i = 0; i < 8; i++) body.push_back(pb[i]);
    if (p[1:0] == 2'b11) begin
      c = 16'hFFFF;
      foreach (src_q[k]) begin
        for (int i = 0; i < 8; i++) body.push_back(src_q[k][i]);
        c = c ^ {8'h00, src_q[k]};
        for (int i = 0; i < 8; i++)
          c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      c = ~c;
      for (int i = 0; i < 16; i++) body.push_back(c[i]);
    end
    for (int i = 0; i < 7; i++) all.push_back(1'b0);
    all.push_back(1'b1);
    run = 0;
    foreach (body[i]) begin
      all.push_back(body[i]);
      run = body[i] ? run + 1 : 0;
      if (run == 6) begin
        all.push_back(1'b0);
        run = 0;
      end
    end
    lv = LJ;
    foreach (all[i]) begin
      if (!all[i]) lv = (lv == LJ) ? LK : LJ;
      exp_q.push_back(lv);
    end
    exp_q.push_back(LSE0);
    exp_q.push_back(LSE0);
    exp_q.push_back(LJ);
  endtask

  // Receiver-side view: NRZI decode and destuff the captured line.
  task automatic decode(input int m);
    logic [1:0] prev;
    logic [1:0] lv;
    logic [7:0] by;
    bit bits[$];
    bit b;
    int run;
    dec_q.delete();
    prev = LJ;
    run = 0;
    for (int k = 0; k * m < cap_q.size(); k++) begin
      lv = cap_q[k * m];
      if (lv == LSE0) break;
      b = (lv == prev);
      prev = lv;
      if (k >= 8) begin
        if (run == 6) run = 0;
        else begin
          bits.push_back(b);
          run = b ? run + 1 : 0;
        end
      end
    end
    for (int i = 0; i + 8 <= bits.size(); i += 8) begin
      by = 8'h00;
      for (int j = 0; j < 8; j++) by[j] = bits[i + j];
      dec_q.push_back(by);
    end
  endtask

  task automatic run_pkt(input logic [3:0] p, input int m,
                         input bit repulse, input int exp_bits,
                         input string tag);
    int n_get, n_oe, end_at, cyc, bad, exp_get;
    bit g, first_oe, first_busy, end_oe, end_busy;
    build_exp(p);
    exp_get = (p[1:0] == 2'b11) ? src_q.size() : 0;
    drive_src();
    cap_q.delete();
    n_get = 0; n_oe = 0; end_at = -1; cyc = 0;
    first_oe = 0; first_busy = 0; end_oe = 1; end_busy = 1;
    @(negedge clk_usb);
    pid = p;
    pkt_start = 1'b1;
    @(posedge clk_usb);
    #1 pkt_start = 1'b0;
    while (end_at < 0 && cyc < 4000) begin
      @(negedge clk_usb);
      if (cyc == 0) begin
        first_oe = oe_m;
        first_busy = busy_m;
      end
      if (oe_m) begin
        cap_q.push_back({dp_m, dn_m});
        n_oe++;
      end
      if (end_m) begin
        end_at = cyc;
        end_oe = oe_m;
        end_busy = busy_m;
      end
      g = get_m;
      if (repulse && cyc == 20) begin
        pid = 4'h2;
        pkt_start = 1'b1;
      end
      @(posedge clk_usb);
      #1 pkt_start = 1'b0;
      if (g) begin
        n_get++;
        if (src_q.size() > 0) void'(src_q.pop_front());
        drive_src();
      end
      cyc++;
    end
    chk({tag, "_ended"}, int'(end_at >= 0), 1);
    chk({tag, "_lat_oe"}, first_oe, 1);
    chk({tag, "_lat_busy"}, first_busy, 1);
    chk({tag, "_oe_len"}, n_oe, exp_q.size() * m);
    chk({tag, "_end_at"}, end_at, exp_q.size() * m);
    chk({tag, "_end_idle"}, {end_oe, end_busy}, 0);
    chk({tag, "_gets"}, n_get, exp_get);
    if (exp_bits != 0) chk({tag, "_bits"}, n_oe, exp_bits * m);
    bad = 0;
    for (int i = 0; i < cap_q.size(); i++)
      if (cap_q[i] != cap_q[i - (i % m)]) bad++;
    chk({tag, "_hold"}, bad, 0);
    bad = 0;
    foreach (exp_q[k])
      if (k * m >= cap_q.size() || cap_q[k * m] != exp_q[k]) bad++;
    chk({tag, "_line"}, bad, 0);
    src_q.delete();
    drive_src();
  endtask

  typedef struct {
    logic [3:0] pid;
    int         nb;
    logic [7:0] d [4];
    int         bits;
  } vec_t;

  vec_t tbl[7];

  logic [1:0] ack_ls [19];

  initial begin
    int bad, cnt, nexp;
    logic [15:0] c;
    logic [3:0] p;
    logic [3:0] pids [5];

    tbl[0] = '{4'h2, 0, '{8'h00, 8'h00, 8'h00, 8'h00}, 19};
    tbl[1] = '{4'hA, 0, '{8'h00, 8'h00, 8'h00, 8'h00}, 19};
    tbl[2] = '{4'hE, 0, '{8'h00, 8'h00, 8'h00, 8'h00}, 19};
    tbl[3] = '{4'h3, 0, '{8'h00, 8'h00, 8'h00, 8'h00}, 35};
    tbl[4] = '{4'hB, 0, '{8'h00, 8'h00, 8'h00, 8'h00}, 35};
    tbl[5] = '{4'hB, 4, '{8'h01, 8'h02, 8'h03, 8'h04}, 0};
    tbl[6] = '{4'h3, 2, '{8'hFF, 8'hFF, 8'h00, 8'h00}, 0};
    ack_ls = '{LK, LJ, LK, LJ, LK, LJ, LK, LK,
               LJ, LJ, LK, LJ, LJ, LK, LK, LK,
               LSE0, LSE0, LJ};
    pids = '{4'h2, 4'hA, 4'hE, 4'h3, 4'hB};

    repeat (3) @(posedge clk_usb);
    @(negedge clk_usb);
    chk("rst_outs", {oe4, dp4, dn4, busy4, get4, end4}, 6'b010000);
    reset = 1'b0;
    repeat (2) @(negedge clk_usb);

    for (int i = 0; i < 7; i++) begin
      src_q.delete();
      for (int k = 0; k < tbl[i].nb; k++) src_q.push_back(tbl[i].d[k]);
      run_pkt(tbl[i].pid, 4, 0, tbl[i].bits, $sformatf("tbl%0d", i));
      decode(4);
      nexp = 1 + tbl[i].nb + ((tbl[i].pid[1:0] == 2'b11) ? 2 : 0);
      chk($sformatf("tbl%0d_nbytes", i), dec_q.size(), nexp);
      if (dec_q.size() == nexp) begin
        chk($sformatf("tbl%0d_pid", i), dec_q[0],
            {~tbl[i].pid, tbl[i].pid});
        bad = 0;
        for (int k = 0; k < tbl[i].nb; k++)
          if (dec_q[1 + k] != tbl[i].d[k]) bad++;
        chk($sformatf("tbl%0d_payload", i), bad, 0);
        if (tbl[i].pid[1:0] == 2'b11) begin
          c = 16'hFFFF;
          for (int k = 1; k < dec_q.size(); k++) begin
            c = c ^ {8'h00, dec_q[k]};
            for (int j = 0; j < 8; j++)
              c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
          end
          chk($sformatf("tbl%0d_crc_resid", i), c, 16'hB001);
          if (tbl[i].nb == 0)
            chk($sformatf("tbl%0d_crc_zero", i),
                {dec_q[1], dec_q[2]}, 0);
        end
      end
      if (i == 0) begin
        bad = 0;
        for (int k = 0; k < 19; k++)
          if (k * 4 >= cap_q.size() || cap_q[k * 4] != ack_ls[k]) bad++;
        chk("ack_wire", bad, 0);
      end
    end

    src_q = '{8'hA5, 8'h5A, 8'hFF};
    run_pkt(4'h3, 4, 1, 0, "repulse");

    src_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    drive_src();
    @(negedge clk_usb);
    pid = 4'hB;
    pkt_start = 1'b1;
    @(posedge clk_usb);
    #1 pkt_start = 1'b0;
    cnt = 0;
    for (int k = 0; k < 2000 && cnt < 2; k++) begin
      @(negedge clk_usb);
      if (get4) cnt++;
    end
    chk("midrst_reach_data", cnt, 2);
    repeat (6) @(negedge clk_usb);
    reset = 1'b1;
    @(posedge clk_usb);
    #1;
    chk("midrst_outs", {oe4, dp4, dn4, busy4, end4}, 5'b01000);
    @(negedge clk_usb);
    reset = 1'b0;
    src_q.delete();
    drive_src();
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_usb);
      if (end4 || oe4 || busy4) cnt++;
    end
    chk("midrst_quiet", cnt, 0);
    run_pkt(4'h2, 4, 0, 19, "after_rst");

    for (int r = 0; r < 12; r++) begin
      p = pids[$urandom_range(0, 4)];
      src_q.delete();
      cnt = $urandom_range(0, 5);
      for (int k = 0; k < cnt; k++)
        src_q.push_back(($urandom_range(0, 2) == 0) ? 8'hFF
                                                     : 8'($urandom));
      run_pkt(p, 4, 0, 0, $sformatf("rnd%0d", r));
    end

    sel = 1'b1;
    repeat (2) @(negedge clk_usb);
    run_pkt(4'h2, 5, 0, 19, "m5_ack");
    sel = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
